io_trace_buffer: RTL
====================

# io_trace_buffer

Wishbone-readable capture buffer that sits downstream of the design multiplexer. It samples the 27-bit design pin bus (`dsi_all`) on every rising edge of the multiplexed design clock (`design_clk_o`) once a programmable trigger matches. It stores up to DEPTH words and lets firmware read them back through the Caravel Wishbone slave port, so a design can be traced without an external logic analyser.

## Interface
- DEPTH, 16: FIFO depth in words; power of two, 2..16.
- wb_clk_i  in  1  sole clock; all state is in this domain.
- wb_rst_n  in  1  reset; asynchronous assert, active-low.
- design_clk_i  in  1  multiplexed design clock (`design_clk_o`), treated as data and synchronised internally.
- sample_bus  in  27  design pin bus (`dsi_all`).
- wbs_adr_i  in  32  byte address; only bits [3:2] are decoded.
- wbs_dat_i  in  32  write data.
- wbs_we_i  in  1  write enable.
- wbs_cyc_i, wbs_stb_i  in  1 each  request qualifiers; valid = cyc & stb.
- wbs_dat_o  out  32  read data, registered.
- wbs_ack_o  out  1  single-cycle acknowledge.
- trig_o  out  1  one-cycle pulse when the trigger fires.

## Operation
- **Sync path**
  - design_clk_i passes through 2 flops, s1 then s2, plus an edge flop s3.
  - A capture edge occurs when s2 & !s3.
  - sample_bus is registered in two matching stages, so the word used on an edge is sample_bus as registered on the same wb_clk_i edge that first saw design_clk_i high in s1.
- **Registers** (adr[3:2]):
  - 0 CTRL/STATUS
    - Write: bit0 ARM, bit1 ABORT, bits[12:8] LEN. LEN = 0 means DEPTH; LEN > DEPTH is clamped to DEPTH.
    - Read: [1:0] state, [2] underflow, [7:3] fifo count, [12:8] LEN, rest 0.
  - 1 DATA
    - Read pops the FIFO head and returns {5'b0, word}. Reading when empty returns 0 and sets sticky underflow.
    - Write is ignored.
  - 2 MASK: bits [26:0], read/write.
  - 3 VALUE: bits [26:0], read/write.
- **Trigger**: hit = ((sample & MASK) == (VALUE & MASK)), evaluated only on capture edges. MASK = 0 triggers on the first edge.
- **State machine** (state encoding in brackets):
  - IDLE (0)
    - ARM → ARMED.
    - ARM flushes the FIFO, clears underflow and clears the captured counter.
  - ARMED (1)
    - On a capture edge with hit: push that sample (it is word 0), pulse trig_o, go to CAPTURE.
    - If LEN = 1, go straight to DONE instead.
  - CAPTURE (2)
    - Push on every capture edge.
    - After LEN words are pushed, or when the FIFO becomes full, go to DONE.
  - DONE (3)
    - No pushes.
    - ARM → ARMED with a flush.
  - ABORT from any state → IDLE. Pushes stop; FIFO contents are kept.
  - ARM and ABORT written together: ABORT wins.
  - ARM while ARMED or CAPTURE restarts the capture with a flush.
- **FIFO**
  - Circular buffer with wrapping read/write pointers and a count of 0..DEPTH.
  - Push while full is dropped; this can only occur through a missed transition, and the bench checks it never happens.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - If the FIFO is empty in that cycle, the pop returns 0 and flags underflow.
  - LEN counts pushes, not pops. Reads during CAPTURE do not extend the capture.
- **Reset values**: state IDLE; wbs_ack_o 0; wbs_dat_o 0; trig_o 0; MASK 0; VALUE 0; LEN 0; pointers 0; count 0; underflow 0; sync flops 0.

## Timing
- **Wishbone handshake**
  - A request is accepted when valid & !wbs_ack_o.
  - wbs_ack_o is high for exactly the next cycle, with wbs_dat_o valid in that same cycle.
  - Sustained valid gives one access every 2 cycles.
  - Write side effects (register update, ARM/ABORT action, pop on a DATA read) take place on the accept edge.
- **Capture latency**: design_clk_i rising → push happens 3 wb_clk_i edges later. trig_o pulses in the same cycle as the trigger push.
- **Minimum design clock**: design_clk_i high and low phases must each be ≥ 2 wb_clk_i periods. Faster clocks alias, and that is not detected.
- **Ordering**: a DATA read accepted in the same cycle as a push returns the old head. The pushed word becomes visible on the following read.
- **Reset**: asynchronous deassert-to-first-access takes 1 cycle. Reset mid-capture discards everything.

## Test plan
- **Basic capture**: MASK=0, LEN=4, ARM, then 4 design clocks with bus = 1,2,3,4 → state DONE, count 4; DATA reads return 1,2,3,4, then 0 with underflow set.
- **Triggered capture**: MASK=0x7FFFFFF, VALUE=0x55, LEN=0, bus counting 0x50..0x6F → trig_o pulses once at 0x55; the FIFO holds 0x55..0x64 (16 words); the state reaches DONE on full.
- **Concurrent read**: LEN=0; pop one word during CAPTURE in the same cycle as a push → count unchanged and the data order is preserved. Capture still ends after 16 pushes, with count 15.
- **Control collisions**: ARM+ABORT in one write → IDLE. Re-ARM during CAPTURE with 5 words stored → count 0 and state ARMED.
- **Handshake and reset**: valid held high for 10 cycles → exactly 5 ack pulses, each 1 cycle wide. wb_rst_n low mid-capture → all outputs and registers return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/io_trace_buffer.sv
// io_trace_buffer: triggered capture of the design pin bus into a FIFO, read back over Wishbone.
module io_trace_buffer #(
  parameter int DEPTH = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        design_clk_i,
  input  logic [26:0] sample_bus,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        trig_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] DW = 5'(DEPTH);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t state, state_n;
  logic s1, s2, s3;
  logic [26:0] b1, b2, mask, value;
  logic [26:0] mem [DEPTH];
  logic [4:0] len, len_eff, count, cap_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic underflow, accept, ctrl_wr, pop, empty, full, cap_edge, hit, last, push, flush, wr_en;
  logic [31:0] rdata;
  logic unused;
  assign unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:27]};
  assign accept = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign ctrl_wr = accept & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
  assign pop = accept & ~wbs_we_i & (wbs_adr_i[3:2] == 2'd1);
  assign empty = count == 5'd0;
  assign full = count == DW;
  assign cap_edge = s2 & ~s3;
  assign hit = (b2 & mask) == (value & mask);
  assign len_eff = (len == 5'd0 || len > DW) ? DW : len;
  // capture ends on the LEN-th push or on the push that fills the FIFO
  assign last = (cap_cnt + 5'd1 >= len_eff) || (count == DW - 5'd1 && !pop);
  assign wr_en = push & ~full;
  assign rdata = wbs_adr_i[3:2] == 2'd0 ? {19'b0, len, count, underflow, state} :
                 wbs_adr_i[3:2] == 2'd1 ? (empty ? 32'd0 : {5'b0, mem[rd_ptr]}) :
                 wbs_adr_i[3:2] == 2'd2 ? {5'b0, mask} : {5'b0, value};
  always_comb begin
    state_n = state;
    push = 1'b0;
    flush = 1'b0;
    if (ctrl_wr && wbs_dat_i[1]) state_n = IDLE;
    else if (ctrl_wr && wbs_dat_i[0]) begin
      state_n = ARMED;
      flush = 1'b1;
    end else if (cap_edge && (state == CAPTURE || (state == ARMED && hit))) begin
      push = 1'b1;
      state_n = last ? DONE : CAPTURE;
    end
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      {s1, s2, s3} <= 3'b0;
      b1 <= '0;
      b2 <= '0;
      mask <= '0;
      value <= '0;
      len <= '0;
      count <= '0;
      cap_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      underflow <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      trig_o <= 1'b0;
    end else begin
      s1 <= design_clk_i;
      s2 <= s1;
      s3 <= s2;
      b1 <= sample_bus;
      b2 <= b1;
      state <= state_n;
      wbs_ack_o <= accept;
      trig_o <= push && state == ARMED;
      if (accept) wbs_dat_o <= rdata;
      if (ctrl_wr) len <= wbs_dat_i[12:8];
      if (accept && wbs_we_i && wbs_adr_i[3:2] == 2'd2) mask <= wbs_dat_i[26:0];
      if (accept && wbs_we_i && wbs_adr_i[3:2] == 2'd3) value <= wbs_dat_i[26:0];
      if (flush) begin
        count <= '0;
        cap_cnt <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        underflow <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (pop && !empty) rd_ptr <= rd_ptr + AW'(1);
        if (pop && empty) underflow <= 1'b1;
        if (push) cap_cnt <= cap_cnt + 5'd1;
        count <= count + {4'b0, wr_en} - {4'b0, pop & ~empty};
      end
    end
  end
  always_ff @(posedge wb_clk_i)
    if (wr_en) mem[wr_ptr] <= b2;
endmodule
